// File: rtl/mig_rd_engine_pkg.sv
// ----------------------------------------------------------------------------
// mig_pkg
// Shared definitions for the MIG native-interface engines.
//   MIG_CMD_READ / MIG_CMD_WRITE : app_cmd encodings understood by the MIG
//   rd_state_t                   : state encoding of the read engine FSM
// No ports; imported with "import mig_pkg::*;".
// ----------------------------------------------------------------------------
package mig_pkg;

   localparam logic [2:0] MIG_CMD_READ  = 3'b001;
   localparam logic [2:0] MIG_CMD_WRITE = 3'b000;

   // IDLE  : waiting for a request, the only state that accepts one
   // CMD   : issuing read commands (read data may already be returning)
   // DRAIN : all commands accepted, waiting for the remaining beats
   // DONE  : one-cycle completion pulse
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rd_state_t;

endpackage

// File: rtl/mig_rd_engine_if.sv
// ----------------------------------------------------------------------------
// Interfaces used by mig_rd_engine.
//
// mig_rd_user_if : user-side request and read-data return.
//   rd_req / rd_req_ready / rd_req_addr / rd_length  request handshake
//   rd_busy                                           transfer in progress
//   rd_data / rd_data_valid / rd_data_last            returned beats
//   rd_done                                           completion pulse
//   modport master : the user logic issuing requests
//   modport slave  : the read engine
//
// mig_app_rd_if : read subset of the MIG native app interface.
//   app_rd_addr / app_rd_cmd / app_rd_en / app_rdy    command channel
//   app_rd_data / app_rd_data_valid / app_rd_data_end read data channel
//   modport master : the read engine
//   modport slave  : the MIG (or its model)
// ----------------------------------------------------------------------------
interface mig_rd_user_if #(
   parameter int ADDR_W = 28,
   parameter int LEN_W  = 16,
   parameter int DATA_W = 128
);
   logic              rd_req;
   logic              rd_req_ready;
   logic [ADDR_W-1:0] rd_req_addr;
   logic [LEN_W-1:0]  rd_length;
   logic              rd_busy;
   logic [DATA_W-1:0] rd_data;
   logic              rd_data_valid;
   logic              rd_data_last;
   logic              rd_done;

   modport master (
      output rd_req, rd_req_addr, rd_length,
      input  rd_req_ready, rd_busy, rd_data, rd_data_valid, rd_data_last, rd_done
   );

   modport slave (
      input  rd_req, rd_req_addr, rd_length,
      output rd_req_ready, rd_busy, rd_data, rd_data_valid, rd_data_last, rd_done
   );
endinterface

interface mig_app_rd_if #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
);
   logic [ADDR_W-1:0] app_rd_addr;
   logic [2:0]        app_rd_cmd;
   logic              app_rd_en;
   logic              app_rdy;
   logic [DATA_W-1:0] app_rd_data;
   logic              app_rd_data_valid;
   logic              app_rd_data_end;

   modport master (
      output app_rd_addr, app_rd_cmd, app_rd_en,
      input  app_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
   );

   modport slave (
      input  app_rd_addr, app_rd_cmd, app_rd_en,
      output app_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
   );
endinterface

// File: rtl/mig_rd_engine_credit_cnt.sv
// ----------------------------------------------------------------------------
// mig_credit_cnt
// Saturating up/down counter of commands accepted by the MIG whose data has
// not yet come back. Shared by the read and write engines.
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset
//   clr_i   : synchronous clear (start of a new transfer)
//   inc_i   : one command accepted this cycle
//   dec_i   : one completion returned this cycle
//   cnt_o   : current count
//   full_o  : count has reached MAX_CNT, no more commands may be issued
// ----------------------------------------------------------------------------
module mig_credit_cnt #(
   parameter int MAX_CNT = 32,
   parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             full_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             inc_ok;
   logic             dec_ok;

   // An increment at full or a decrement at zero is dropped, so the count
   // can neither exceed MAX_CNT nor underflow on a stray completion.
   assign full_o = (cnt_q >= CNT_W'(MAX_CNT));
   assign inc_ok = inc_i && !full_o;
   assign dec_ok = dec_i && (cnt_q != '0);
   assign cnt_o  = cnt_q;

   // Next count: a simultaneous accepted increment and decrement cancel.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_ok && !dec_ok) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (dec_ok && !inc_ok) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mig_rd_engine.sv
// ----------------------------------------------------------------------------
// mig_rd_engine
// Read engine between user logic and the MIG native app interface. One
// request (start address, length in beats) becomes `length` read commands at
// a fixed ADDR_STEP stride. In-flight commands are capped at MAX_OUTST by a
// credit counter. Read data is passed straight through with a per-beat valid,
// a last-beat marker and a registered done pulse.
//   ui_clk  : single clock, rising edge
//   rst_n   : synchronous active-low reset
//   usr_if  : user request / data return (mig_rd_user_if.slave)
//   app_if  : MIG read command and data channels (mig_app_rd_if.master)
// ----------------------------------------------------------------------------
module mig_rd_engine
   import mig_pkg::*;
#(
   parameter int DATA_W    = 128,
   parameter int ADDR_W    = 28,
   parameter int LEN_W     = 16,
   parameter int ADDR_STEP = 8,
   parameter int MAX_OUTST = 32,
   parameter int OUTST_W   = $clog2(MAX_OUTST + 1)
) (
   input logic           ui_clk,
   input logic           rst_n,
   mig_rd_user_if.slave  usr_if,
   mig_app_rd_if.master  app_if
);

   rd_state_t         state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cmd_cnt_q, cmd_cnt_d;
   logic [LEN_W-1:0]  dat_cnt_q, dat_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic               req_acc;
   logic               beat_ok;
   logic               last_beat;
   logic               cmd_en;
   logic               cmd_acc;
   logic               outst_full;
   logic [OUTST_W-1:0] outst_cnt_unused;
   logic               data_end_unused;

   // The MIG end-of-burst flag carries no information for single-beat
   // accounting; it is deliberately left unconnected.
   assign data_end_unused = app_if.app_rd_data_end;

   // Returned beats only count while a transfer is collecting data; anything
   // arriving in IDLE or DONE (e.g. left over from before a reset) is dropped.
   assign req_acc   = (state_q == IDLE) && usr_if.rd_req;
   assign beat_ok   = app_if.app_rd_data_valid && ((state_q == CMD) || (state_q == DRAIN));
   assign last_beat = beat_ok && (dat_cnt_q == (len_q - LEN_W'(1)));

   // Command valid never looks at app_rdy, so address and enable stay put
   // until the MIG takes the command.
   assign cmd_en  = (state_q == CMD) && (cmd_cnt_q < len_q) && !outst_full;
   assign cmd_acc = cmd_en && app_if.app_rdy;

   // Outstanding-command credits, cleared when a new request is taken.
   mig_credit_cnt #(
      .MAX_CNT (MAX_OUTST),
      .CNT_W   (OUTST_W)
   ) u_credit (
      .clk_i   (ui_clk),
      .rst_ni  (rst_n),
      .clr_i   (req_acc),
      .inc_i   (cmd_acc),
      .dec_i   (beat_ok),
      .cnt_o   (outst_cnt_unused),
      .full_o  (outst_full)
   );

   // Next-state logic. The address register is loaded with the start address
   // on acceptance and advanced by one stride per accepted command, wrapping
   // at 2^ADDR_W. The final beat ends the transfer from either CMD or DRAIN.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cmd_cnt_d = cmd_cnt_q;
      dat_cnt_d = dat_cnt_q;
      addr_d    = addr_q;

      if (beat_ok) begin
         dat_cnt_d = dat_cnt_q + LEN_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (usr_if.rd_req) begin
               len_d     = usr_if.rd_length;
               addr_d    = usr_if.rd_req_addr;
               cmd_cnt_d = '0;
               dat_cnt_d = '0;
               state_d   = (usr_if.rd_length == '0) ? DONE : CMD;
            end
         end
         CMD: begin
            if (cmd_acc) begin
               cmd_cnt_d = cmd_cnt_q + LEN_W'(1);
               addr_d    = addr_q + ADDR_W'(ADDR_STEP);
            end
            if (last_beat) begin
               state_d = DONE;
            end else if (cmd_acc && (cmd_cnt_q == (len_q - LEN_W'(1)))) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (last_beat) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge ui_clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         len_q     <= '0;
         cmd_cnt_q <= '0;
         dat_cnt_q <= '0;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cmd_cnt_q <= cmd_cnt_d;
         dat_cnt_q <= dat_cnt_d;
         addr_q    <= addr_d;
      end
   end

   // rd_done is decoded straight from the state register, so it is glitch
   // free and lasts exactly the one DONE cycle.
   assign usr_if.rd_req_ready  = (state_q == IDLE);
   assign usr_if.rd_busy       = (state_q != IDLE);
   assign usr_if.rd_data       = app_if.app_rd_data;
   assign usr_if.rd_data_valid = beat_ok;
   assign usr_if.rd_data_last  = last_beat;
   assign usr_if.rd_done       = (state_q == DONE);

   assign app_if.app_rd_addr   = addr_q;
   assign app_if.app_rd_cmd    = MIG_CMD_READ;
   assign app_if.app_rd_en     = cmd_en;

endmodule

// File: tb/tb_mig_rd_engine.sv
// ----------------------------------------------------------------------------
// tb_mig_rd_engine
// Directed bench for mig_rd_engine. A MIG model returns one beat per accepted
// command after a programmable latency. A transaction-level model of the
// engine is checked against the DUT on every cycle, and each directed test
// also pins a few hand-computed values.
// ----------------------------------------------------------------------------
module tb_mig_rd_engine;

   localparam int DATA_W    = 128;
   localparam int ADDR_W    = 28;
   localparam int LEN_W     = 16;
   localparam int ADDR_STEP = 8;
   localparam int MAX_OUTST = 2;

   logic ui_clk = 1'b0;
   logic rst_n;

   mig_rd_user_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) userIf ();
   mig_app_rd_if  #(.ADDR_W(ADDR_W), .DATA_W(DATA_W))                appIf ();

   mig_rd_engine #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .LEN_W     (LEN_W),
      .ADDR_STEP (ADDR_STEP),
      .MAX_OUTST (MAX_OUTST)
   ) dut (
      .ui_clk (ui_clk),
      .rst_n  (rst_n),
      .usr_if (userIf),
      .app_if (appIf)
   );

   always #5 ui_clk = ~ui_clk;

   // Free-running cycle index, visible to every process from posedge+1.
   int cyc = 0;
   always @(posedge ui_clk) cyc <= cyc + 1;

   int nChecks = 0;
   int nFails  = 0;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------------
   // MIG model: each accepted command returns one beat `lat` cycles later.
   // strayValid forces extra valids that belong to no command.
   // ------------------------------------------------------------------
   int  lat = 3;
   bit  strayValid = 1'b0;
   int  retQ[$];
   int  seq = 0;

   initial begin : migModel
      logic [31:0] w;
      appIf.app_rd_data_valid = 1'b0;
      appIf.app_rd_data       = '0;
      appIf.app_rd_data_end   = 1'b0;
      forever begin
         @(negedge ui_clk);
         if (appIf.app_rd_en === 1'b1 && appIf.app_rdy === 1'b1) retQ.push_back(cyc + lat);
         @(posedge ui_clk);
         #1;
         appIf.app_rd_data_valid = 1'b0;
         if (retQ.size() > 0 && retQ[0] <= cyc) begin
            void'(retQ.pop_front());
            appIf.app_rd_data_valid = 1'b1;
         end else if (strayValid) begin
            appIf.app_rd_data_valid = 1'b1;
         end
         appIf.app_rd_data_end = appIf.app_rd_data_valid;
         if (appIf.app_rd_data_valid) begin
            seq++;
            w = 32'hBEEF0000 + 32'(seq);
            appIf.app_rd_data = {w, ~w, w ^ 32'h5A5A5A5A, 32'(cyc)};
         end
      end
   end

   // ------------------------------------------------------------------
   // Transaction model and per-cycle compare, plus a monitor log of what
   // the DUT actually did for the directed literal checks.
   // ------------------------------------------------------------------
   bit chkOn = 1'b0;

   bit                mActive = 1'b0;
   bit                mDone   = 1'b0;
   int                mLen    = 0;
   int                mIssued = 0;
   int                mBeats  = 0;
   int                mOut    = 0;
   logic [ADDR_W-1:0] mAddr   = '0;

   logic [ADDR_W-1:0] accLog[$];
   int beatTotal   = 0;
   int lastTotal   = 0;
   int doneTotal   = 0;
   int lastBeatCyc = -1;
   int doneCyc     = -1;

   initial begin : compareProc
      bit expEn, expValid, expLast, accept, decOk;
      wait (chkOn == 1'b1);
      forever begin
         @(negedge ui_clk);
         expEn    = mActive && !mDone && (mIssued < mLen) && (mOut < MAX_OUTST);
         expValid = (appIf.app_rd_data_valid === 1'b1) && mActive && !mDone;
         expLast  = expValid && (mBeats == mLen - 1);

         checkOutput("rd_req_ready",  128'(userIf.rd_req_ready),  128'(!mActive));
         checkOutput("rd_busy",       128'(userIf.rd_busy),       128'(mActive));
         checkOutput("rd_done",       128'(userIf.rd_done),       128'(mDone));
         checkOutput("app_rd_en",     128'(appIf.app_rd_en),      128'(expEn));
         checkOutput("app_rd_addr",   128'(appIf.app_rd_addr),    128'(mAddr));
         checkOutput("app_rd_cmd",    128'(appIf.app_rd_cmd),     128'(3'b001));
         checkOutput("rd_data_valid", 128'(userIf.rd_data_valid), 128'(expValid));
         checkOutput("rd_data_last",  128'(userIf.rd_data_last),  128'(expLast));
         if (expValid) checkOutput("rd_data", userIf.rd_data, appIf.app_rd_data);

         if (appIf.app_rd_en === 1'b1 && appIf.app_rdy === 1'b1) accLog.push_back(appIf.app_rd_addr);
         if (userIf.rd_data_valid === 1'b1) beatTotal++;
         if (userIf.rd_data_last === 1'b1) begin
            lastTotal++;
            lastBeatCyc = cyc;
         end
         if (userIf.rd_done === 1'b1) begin
            doneTotal++;
            doneCyc = cyc;
         end

         accept = expEn && (appIf.app_rdy === 1'b1);
         decOk  = expValid && (mOut > 0);
         if (rst_n !== 1'b1) begin
            mActive = 1'b0;
            mDone   = 1'b0;
            mOut    = 0;
            mAddr   = '0;
         end else if (!mActive) begin
            if (userIf.rd_req === 1'b1) begin
               mActive = 1'b1;
               mLen    = int'(userIf.rd_length);
               mIssued = 0;
               mBeats  = 0;
               mOut    = 0;
               mAddr   = userIf.rd_req_addr;
               mDone   = (mLen == 0);
            end
         end else if (mDone) begin
            mActive = 1'b0;
            mDone   = 1'b0;
         end else begin
            if (accept) begin
               mIssued++;
               mAddr = mAddr + ADDR_W'(ADDR_STEP);
            end
            if (accept && !decOk) mOut++;
            else if (decOk && !accept) mOut--;
            if (expValid) begin
               mBeats++;
               if (mBeats == mLen) mDone = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   int doneBase = 0;
   int reqCyc   = 0;

   task automatic applyStimulus(input logic [ADDR_W-1:0] a, input int len);
      @(posedge ui_clk);
      #1;
      doneBase            = doneTotal;
      reqCyc              = cyc;
      userIf.rd_req       = 1'b1;
      userIf.rd_req_addr  = a;
      userIf.rd_length    = LEN_W'(len);
      @(posedge ui_clk);
      #1;
      userIf.rd_req       = 1'b0;
   endtask

   task automatic waitDone(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (doneTotal > doneBase) break;
         @(negedge ui_clk);
         #2;
      end
      checkOutput("rd_done_within_budget", 128'(doneTotal > doneBase), 128'(1));
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_rd_req_ready"},  128'(userIf.rd_req_ready),  128'(1));
      checkOutput({tag, "_rd_busy"},       128'(userIf.rd_busy),       128'(0));
      checkOutput({tag, "_app_rd_en"},     128'(appIf.app_rd_en),      128'(0));
      checkOutput({tag, "_app_rd_addr"},   128'(appIf.app_rd_addr),    128'(0));
      checkOutput({tag, "_app_rd_cmd"},    128'(appIf.app_rd_cmd),     128'(3'b001));
      checkOutput({tag, "_rd_done"},       128'(userIf.rd_done),       128'(0));
      checkOutput({tag, "_rd_data_valid"}, 128'(userIf.rd_data_valid), 128'(0));
      checkOutput({tag, "_rd_data_last"},  128'(userIf.rd_data_last),  128'(0));
   endtask

   // ------------------------------------------------------------------
   // Directed tests
   // ------------------------------------------------------------------
   initial begin : stimulus
      int accBase, beatBase, lastBase;
      logic [ADDR_W-1:0] t1Addr[4];
      logic [ADDR_W-1:0] t6Addr[3];
      t1Addr = '{28'h100, 28'h108, 28'h110, 28'h118};
      t6Addr = '{28'h600, 28'h608, 28'h610};

      rst_n              = 1'b0;
      userIf.rd_req      = 1'b0;
      userIf.rd_req_addr = '0;
      userIf.rd_length   = '0;
      appIf.app_rdy      = 1'b1;

      repeat (2) @(posedge ui_clk);
      #1 chkOn = 1'b1;
      @(posedge ui_clk);
      #1 rst_n = 1'b1;
      @(negedge ui_clk);
      #1;
      checkResetOutputs("reset");

      // Length 4 from 0x100, MIG always ready, 3-cycle data latency.
      lat      = 3;
      accBase  = accLog.size();
      beatBase = beatTotal;
      lastBase = lastTotal;
      applyStimulus(28'h100, 4);
      waitDone(100);
      checkOutput("t1_cmd_count", 128'(accLog.size() - accBase), 128'(4));
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("t1_addr%0d", i), 128'(accLog[accBase + i]), 128'(t1Addr[i]));
      checkOutput("t1_beats",          128'(beatTotal - beatBase), 128'(4));
      checkOutput("t1_last_count",     128'(lastTotal - lastBase), 128'(1));
      checkOutput("t1_done_after_last", 128'(doneCyc), 128'(lastBeatCyc + 1));

      // app_rdy low for 5 cycles mid-burst: command held, none lost or doubled.
      lat      = 2;
      accBase  = accLog.size();
      beatBase = beatTotal;
      applyStimulus(28'h2000, 6);
      @(posedge ui_clk);
      #1 appIf.app_rdy = 1'b0;
      repeat (5) @(posedge ui_clk);
      #1 appIf.app_rdy = 1'b1;
      waitDone(200);
      checkOutput("t2_cmd_count", 128'(accLog.size() - accBase), 128'(6));
      for (int i = 0; i < 6; i++)
         checkOutput($sformatf("t2_addr%0d", i), 128'(accLog[accBase + i]), 128'(28'h2000 + 8 * i));
      checkOutput("t2_beats", 128'(beatTotal - beatBase), 128'(6));

      // Credit throttling: two commands in flight, data 10 cycles late.
      lat      = 10;
      accBase  = accLog.size();
      beatBase = beatTotal;
      applyStimulus(28'h40000, 8);
      repeat (8) @(posedge ui_clk);
      @(negedge ui_clk);
      #1;
      checkOutput("t3_cmds_before_data", 128'(accLog.size() - accBase), 128'(2));
      checkOutput("t3_en_throttled",     128'(appIf.app_rd_en),         128'(0));
      waitDone(300);
      checkOutput("t3_cmd_count", 128'(accLog.size() - accBase), 128'(8));
      checkOutput("t3_beats",     128'(beatTotal - beatBase),    128'(8));

      // Zero length: done one cycle after acceptance, no command.
      lat     = 3;
      accBase = accLog.size();
      applyStimulus(28'h1234, 0);
      waitDone(10);
      checkOutput("t4_zero_no_cmd",   128'(accLog.size() - accBase), 128'(0));
      checkOutput("t4_zero_done_cyc", 128'(doneCyc),                 128'(reqCyc + 1));

      // A request while busy is ignored.
      accBase = accLog.size();
      applyStimulus(28'h3000, 3);
      userIf.rd_req      = 1'b1;
      userIf.rd_req_addr = 28'h9000;
      userIf.rd_length   = 16'd5;
      @(posedge ui_clk);
      #1 userIf.rd_req = 1'b0;
      waitDone(100);
      repeat (3) @(negedge ui_clk);
      #1;
      checkOutput("t4_busy_req_ignored", 128'(accLog.size() - accBase), 128'(3));
      checkOutput("t4_idle_after",       128'(userIf.rd_req_ready),     128'(1));

      // Address wrap at 2^28.
      accBase = accLog.size();
      applyStimulus(28'hFFFFFF8, 2);
      waitDone(100);
      checkOutput("t5_cmd_count", 128'(accLog.size() - accBase), 128'(2));
      checkOutput("t5_addr0",     128'(accLog[accBase]),         128'(28'hFFFFFF8));
      checkOutput("t5_addr1",     128'(accLog[accBase + 1]),     128'(28'h0000000));

      // Reset mid-transfer, late and stray valids dropped, then a clean run.
      lat = 4;
      applyStimulus(28'h500, 6);
      repeat (3) @(posedge ui_clk);
      #1 rst_n = 1'b0;
      @(posedge ui_clk);
      #1 rst_n = 1'b1;
      @(negedge ui_clk);
      #1;
      checkResetOutputs("t6_after_reset");
      for (int i = 0; i < 50; i++) begin
         if (retQ.size() == 0) break;
         @(posedge ui_clk);
         #2;
      end
      checkOutput("t6_mig_drained", 128'(retQ.size()), 128'(0));
      @(negedge ui_clk);
      #1 strayValid = 1'b1;
      @(negedge ui_clk);
      #1;
      checkOutput("t6_stray_gated", 128'(userIf.rd_data_valid), 128'(0));
      strayValid = 1'b0;
      repeat (2) @(posedge ui_clk);
      lat      = 3;
      accBase  = accLog.size();
      beatBase = beatTotal;
      applyStimulus(28'h600, 3);
      waitDone(100);
      checkOutput("t6_cmd_count", 128'(accLog.size() - accBase), 128'(3));
      for (int i = 0; i < 3; i++)
         checkOutput($sformatf("t6_addr%0d", i), 128'(accLog[accBase + i]), 128'(t6Addr[i]));
      checkOutput("t6_beats", 128'(beatTotal - beatBase), 128'(3));

      repeat (5) @(posedge ui_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   // Hard stop if the directed sequence ever stalls.
   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
